// File: rtl/magnitude_sched_pkg.sv
// Shared constants and helpers for the magnitude round-robin scheduler.
package magnitude_sched_pkg;

   // Width and saturation value of the per-channel dropped-sample counters.
   localparam int DROP_CNT_W = 16;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

   // Width of a channel index; kept at least 1 bit so a field always exists.
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/magnitude_rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting at
// ptr_i, wrapping modulo NB_CHAN, and grants the first requester found.
module magnitude_rr_arbiter #(
   parameter int NB_CHAN = 4,
   parameter int CHAN_W  = 2
) (
   input  logic [NB_CHAN-1:0] req_i,
   input  logic [CHAN_W-1:0]  ptr_i,
   output logic [NB_CHAN-1:0] gnt_o,
   output logic [CHAN_W-1:0]  gnt_idx_o,
   output logic               gnt_vld_o,
   output logic [CHAN_W-1:0]  ptr_next_o
);

   int                idx;
   logic [CHAN_W-1:0] idx_c;

   // Scan offsets from farthest to nearest so the nearest requester wins last.
   always_comb begin
      gnt_o      = '0;
      gnt_idx_o  = '0;
      gnt_vld_o  = 1'b0;
      ptr_next_o = ptr_i;
      idx        = 0;
      idx_c      = '0;
      for (int off = NB_CHAN - 1; off >= 0; off--) begin
         idx = int'(ptr_i) + off;
         if (idx >= NB_CHAN) begin
            idx = idx - NB_CHAN;
         end
         idx_c = idx[CHAN_W-1:0];
         if (req_i[idx_c]) begin
            gnt_idx_o = idx_c;
            gnt_vld_o = 1'b1;
         end
      end
      if (gnt_vld_o) begin
         gnt_o[gnt_idx_o] = 1'b1;
         ptr_next_o = (gnt_idx_o == CHAN_W'(NB_CHAN - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/magnitude_rr_sched.sv
// Shares one pipelined I^2+Q^2 datapath between NB_CHAN IQ streams. Each
// channel has a one-entry holding register; a round-robin arbiter feeds one
// held sample per cycle into a three-stage square/add pipeline whose output
// is tagged with the source channel.
// Optional build macro MAGNITUDE_RR_SCHED_DROP_CNT_EN adds saturating
// per-channel dropped-sample counters; otherwise drop_cnt_o is tied to 0.
module magnitude_rr_sched
   import magnitude_sched_pkg::*;
#(
   parameter int DATA_SIZE = 16,
   parameter int NB_CHAN   = 4
) (
   input  logic                            data_clk_i,
   input  logic                            data_rst_i,
   input  logic [NB_CHAN*DATA_SIZE-1:0]    data_i_i,
   input  logic [NB_CHAN*DATA_SIZE-1:0]    data_q_i,
   input  logic [NB_CHAN-1:0]              data_en_i,
   input  logic [NB_CHAN-1:0]              data_sof_i,
   input  logic [NB_CHAN-1:0]              data_eof_i,
   input  logic                            clear_ovf_i,
   output logic [2*DATA_SIZE:0]            data_o,
   output logic [chan_w(NB_CHAN)-1:0]      data_chan_o,
   output logic                            data_en_o,
   output logic                            data_sof_o,
   output logic                            data_eof_o,
   output logic [NB_CHAN-1:0]              ovf_o,
   output logic [NB_CHAN*DROP_CNT_W-1:0]   drop_cnt_o,
   output logic                            data_rst_o,
   output logic                            data_clk_o
);

   localparam int CHAN_W = chan_w(NB_CHAN);
   localparam int SQ_W   = 2 * DATA_SIZE;

   logic                         clk;
   logic                         rst_n;

   logic [NB_CHAN-1:0]           hold_vld;
   logic [NB_CHAN-1:0]           hold_sof;
   logic [NB_CHAN-1:0]           hold_eof;
   logic [NB_CHAN*DATA_SIZE-1:0] hold_i;
   logic [NB_CHAN*DATA_SIZE-1:0] hold_q;
   logic [NB_CHAN-1:0]           gnt;
   logic [NB_CHAN-1:0]           drop;
   logic [CHAN_W-1:0]            gnt_idx;
   logic                         gnt_vld;
   logic [CHAN_W-1:0]            ptr_q;
   logic [CHAN_W-1:0]            ptr_d;

   logic signed [DATA_SIZE-1:0]  s1_i_q;
   logic signed [DATA_SIZE-1:0]  s1_q_q;
   logic [CHAN_W-1:0]            s1_chan_q;
   logic                         s1_sof_q;
   logic                         s1_eof_q;
   logic                         s1_en_q;

   logic signed [SQ_W-1:0]       sq_i_d;
   logic signed [SQ_W-1:0]       sq_q_d;
   logic [SQ_W-1:0]              s2_sq_i_q;
   logic [SQ_W-1:0]              s2_sq_q_q;
   logic [CHAN_W-1:0]            s2_chan_q;
   logic                         s2_sof_q;
   logic                         s2_eof_q;
   logic                         s2_en_q;

   assign clk        = data_clk_i;
   assign rst_n      = data_rst_i;
   assign data_clk_o = data_clk_i;
   assign data_rst_o = data_rst_i;

   genvar gi;
   generate
      for (gi = 0; gi < NB_CHAN; gi++) begin : g_chan
         logic                 vld_q;
         logic                 sof_q;
         logic                 eof_q;
         logic                 ovf_q;
         logic                 ovf_d;
         logic [DATA_SIZE-1:0] i_q;
         logic [DATA_SIZE-1:0] q_q;
         logic                 load;

         // A slot accepts a sample when empty or when it is being drained now.
         assign load     = data_en_i[gi] & (~vld_q | gnt[gi]);
         assign drop[gi] = data_en_i[gi] & vld_q & ~gnt[gi];

         // Holding register: load new sample, else clear on grant.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= 1'b0;
               sof_q <= 1'b0;
               eof_q <= 1'b0;
               i_q   <= '0;
               q_q   <= '0;
            end else if (load) begin
               vld_q <= 1'b1;
               sof_q <= data_sof_i[gi];
               eof_q <= data_eof_i[gi];
               i_q   <= data_i_i[gi*DATA_SIZE +: DATA_SIZE];
               q_q   <= data_q_i[gi*DATA_SIZE +: DATA_SIZE];
            end else if (gnt[gi]) begin
               vld_q <= 1'b0;
            end
         end

         // Sticky overflow: a drop in the same cycle beats a clear.
         assign ovf_d = drop[gi] | (ovf_q & ~clear_ovf_i);

         // Overflow flag register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else begin
               ovf_q <= ovf_d;
            end
         end

         assign hold_vld[gi] = vld_q;
         assign hold_sof[gi] = sof_q;
         assign hold_eof[gi] = eof_q;
         assign hold_i[gi*DATA_SIZE +: DATA_SIZE] = i_q;
         assign hold_q[gi*DATA_SIZE +: DATA_SIZE] = q_q;
         assign ovf_o[gi] = ovf_q;

`ifdef MAGNITUDE_RR_SCHED_DROP_CNT_EN
         logic [DROP_CNT_W-1:0] cnt_q;
         logic [DROP_CNT_W-1:0] cnt_d;

         // Saturating drop counter; a drop coinciding with clear restarts at 1.
         always_comb begin
            cnt_d = cnt_q;
            if (drop[gi]) begin
               if (clear_ovf_i) begin
                  cnt_d = DROP_CNT_W'(1);
               end else if (cnt_q != DROP_CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (clear_ovf_i) begin
               cnt_d = '0;
            end
         end

         // Drop counter register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign drop_cnt_o[gi*DROP_CNT_W +: DROP_CNT_W] = cnt_q;
`else
         assign drop_cnt_o[gi*DROP_CNT_W +: DROP_CNT_W] = '0;
`endif
      end
   endgenerate

   magnitude_rr_arbiter #(
      .NB_CHAN (NB_CHAN),
      .CHAN_W  (CHAN_W)
   ) u_arbiter (
      .req_i      (hold_vld),
      .ptr_i      (ptr_q),
      .gnt_o      (gnt),
      .gnt_idx_o  (gnt_idx),
      .gnt_vld_o  (gnt_vld),
      .ptr_next_o (ptr_d)
   );

   // Round-robin pointer; the arbiter returns it unchanged when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Stage 1: capture the granted channel's sample and sideband.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_en_q   <= 1'b0;
         s1_i_q    <= '0;
         s1_q_q    <= '0;
         s1_chan_q <= '0;
         s1_sof_q  <= 1'b0;
         s1_eof_q  <= 1'b0;
      end else begin
         s1_en_q <= gnt_vld;
         if (gnt_vld) begin
            s1_i_q    <= hold_i[gnt_idx*DATA_SIZE +: DATA_SIZE];
            s1_q_q    <= hold_q[gnt_idx*DATA_SIZE +: DATA_SIZE];
            s1_chan_q <= gnt_idx;
            s1_sof_q  <= hold_sof[gnt_idx];
            s1_eof_q  <= hold_eof[gnt_idx];
         end
      end
   end

   // Full-width signed squares; (-2^(N-1))^2 = 2^(2N-2) fits without wrap.
   assign sq_i_d = s1_i_q * s1_i_q;
   assign sq_q_d = s1_q_q * s1_q_q;

   // Stage 2: register squares (non-negative, so stored as unsigned).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_en_q   <= 1'b0;
         s2_sq_i_q <= '0;
         s2_sq_q_q <= '0;
         s2_chan_q <= '0;
         s2_sof_q  <= 1'b0;
         s2_eof_q  <= 1'b0;
      end else begin
         s2_en_q <= s1_en_q;
         if (s1_en_q) begin
            s2_sq_i_q <= sq_i_d;
            s2_sq_q_q <= sq_q_d;
            s2_chan_q <= s1_chan_q;
            s2_sof_q  <= s1_sof_q;
            s2_eof_q  <= s1_eof_q;
         end
      end
   end

   // Stage 3: one-bit-wider sum; outputs hold their last values when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_en_o   <= 1'b0;
         data_o      <= '0;
         data_chan_o <= '0;
         data_sof_o  <= 1'b0;
         data_eof_o  <= 1'b0;
      end else begin
         data_en_o <= s2_en_q;
         if (s2_en_q) begin
            data_o      <= {1'b0, s2_sq_i_q} + {1'b0, s2_sq_q_q};
            data_chan_o <= s2_chan_q;
            data_sof_o  <= s2_sof_q;
            data_eof_o  <= s2_eof_q;
         end
      end
   end

endmodule

// File: doc/magnitude_rr_sched.md
Name: magnitude_rr_sched

Overview:
- Shares one magnitude datapath (I²+Q²) between NB_CHAN independent IQ streams.
- Each channel owns a one-entry holding register; a round-robin arbiter grants one pending channel per cycle into a pipelined shared squarer/adder.
- Output stream is tagged with the source channel index.
- Sits between multi-channel demod/NCO outputs and downstream per-channel averaging/framing blocks.

Parameters:
- DATA_SIZE, 16, width of each signed I/Q sample.
- NB_CHAN, 4, number of requesting channels (2..16).

Ports:
- data_clk_i  in  1  clock; forwarded unchanged on data_clk_o.
- data_rst_i  in  1  asynchronous, active-low reset; forwarded unchanged on data_rst_o.
- data_i_i  in  NB_CHAN*DATA_SIZE  signed I samples, channel k at bits [k*DATA_SIZE +: DATA_SIZE].
- data_q_i  in  NB_CHAN*DATA_SIZE  signed Q samples, same packing.
- data_en_i  in  NB_CHAN  per-channel sample valid.
- data_sof_i  in  NB_CHAN  per-channel start of frame, qualified by data_en_i.
- data_eof_i  in  NB_CHAN  per-channel end of frame, qualified by data_en_i.
- clear_ovf_i  in  1  clears all overflow flags.
- data_o  out  2*DATA_SIZE+1  unsigned I²+Q².
- data_chan_o  out  $clog2(NB_CHAN)  source channel of data_o.
- data_en_o  out  1  output valid.
- data_sof_o  out  1  sof of the granted sample.
- data_eof_o  out  1  eof of the granted sample.
- ovf_o  out  NB_CHAN  sticky per-channel overflow.
- drop_cnt_o  out  NB_CHAN*16  per-channel dropped-sample counters (see Optional Feature).
- data_rst_o  out  1  data_rst_i passthrough.
- data_clk_o  out  1  data_clk_i passthrough.

Behaviour:
- Reset (data_rst_i=0, asynchronous):
  - all hold valids, pipeline valids, data_o, data_chan_o, data_en_o, data_sof_o, data_eof_o, ovf_o and drop counters go to 0;
  - round-robin pointer goes to 0.
  - Reset mid-stream discards all in-flight samples; no output until new input is sampled.
- Capture: on an edge with data_en_i[k]=1 and hold[k] empty, or hold[k] being granted that cycle, hold[k] loads i, q, sof and eof, and valid[k] becomes 1.
- Overflow: data_en_i[k]=1 while hold[k] is valid and not granted that cycle.
  - The new sample is dropped and the held sample is kept.
  - ovf_o[k] is set.
  - If set and clear_ovf_i occur in the same cycle, set wins.
- Arbiter (combinational on hold valids):
  - search starts at channel ptr and wraps modulo NB_CHAN; the first valid channel is granted.
  - On a grant, ptr becomes grant+1 (wraps NB_CHAN-1 -> 0).
  - The granted hold entry clears unless reloaded on the same edge.
  - With no valid channel: no grant, ptr unchanged.
- Pipeline (all registered, 1 sample/cycle aggregate):
  - S1 = selected i, q, chan, sof, eof, en.
  - S2 = signed squares, each 2*DATA_SIZE bits unsigned result, plus sideband.
  - S3 = zero-extended sum into data_o, plus sideband.
- Latency, uncontended: input sampled at edge E0, hold -> S1 at E1, S2 at E2, data_en_o rises at E3.
  - Contention adds one cycle per channel served ahead.
  - Worst case is NB_CHAN-1 extra cycles.
- Lossless guarantee: each channel presents at most one sample per NB_CHAN cycles.
- data_sof_o and data_eof_o travel with their sample. When data_en_o=0, the sideband outputs hold their last values.
- Arithmetic: (-2^(DATA_SIZE-1))² is handled exactly. Maximum result is 2^(2*DATA_SIZE-1), with no overflow in data_o.

Optional Feature:
- Macro: MAGNITUDE_RR_SCHED_DROP_CNT_EN.
- Defined: each dropped sample increments drop_cnt_o[k].
  - 16-bit counter, saturating at 0xFFFF.
  - Cleared by clear_ovf_i, except that an increment in the same cycle wins and the counter is loaded with 1.
- Undefined: no counter logic; drop_cnt_o is tied to 0. ovf_o behaves identically in both builds.

Decomposition:
- Package magnitude_sched_pkg:
  - CHAN_W = $clog2(NB_CHAN) helper function;
  - DROP_CNT_W = 16;
  - DROP_CNT_MAX.
- Sub-module magnitude_rr_arbiter: request vector and ptr in; one-hot grant, grant index and next ptr out. Purely combinational, reusable.
- Hold registers, pipeline and counters stay in the top level.

Test Plan (DATA_SIZE=16, NB_CHAN=4):
- After reset, ch1 in: i=3, q=-4, one cycle -> three edges later data_en_o=1, data_o=25, data_chan_o=1, ovf_o=0.
- ch0 in: i=q=-32768 -> data_o=0x080000000. ch0 in: i=32767, q=0 -> data_o=0x03FFF0001.
- All four channels enabled in one cycle, ptr=0, values i=k+1, q=0 -> four consecutive outputs: chan 0,1,2,3 with data_o 1,4,9,16; ptr ends at 0.
- Continue from ptr=1 with ch0 and ch3 pending -> order ch3, ch0 (wrap-around).
- ch0..ch3 all enabled for 2 consecutive cycles:
  - ch0 is granted on the second edge, so it is reloaded with no drop;
  - ch1, ch2, ch3 drop their second sample, giving ovf_o=4'b1110 and drop_cnt=1 each if the macro is built;
  - pulsing clear_ovf_i gives ovf_o=0.
- ch2 frame of 3 samples (sof on first, eof on last) -> output shows sof on first and eof on third, chan=2.
- Assert reset while 3 samples are in flight -> data_en_o=0 immediately, no outputs after release, ptr=0.
